slice_sequencer: RTL and testbench

SLICE_SEQUENCER -- requirements
Module: slice_sequencer

---
 rtl/slice_sequencer.sv | 176 +++++++++++++++++
 tb/tb_slice_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_sequencer.sv
// slice_sequencer: frame sequencer issuing per-stage slice enables ISSUE_GAP cycles apart, with write-back strobes WB_LATENCY later.
// Overrun detection is included only when SLICE_SEQ_OVERRUN_EN is defined; otherwise overrun is tied low.
module slice_sequencer #(
    parameter int ISSUE_GAP  = 4,
    parameter int WB_LATENCY = 4
) (
    input  logic       clock_200,
    input  logic       reset_n,
    input  logic       sample_strobe,
    input  logic       run,
    input  logic [3:0] num_stages_m1,
    input  logic [4:0] coef_bank,
    input  logic [3:0] log_sel,
    input  logic       overrun_clear,
    output logic       slice_enable,
    output logic [8:0] coefficient_read_adr,
    output logic [3:0] state_read_adr,
    output logic [3:0] state_write_adr,
    output logic       sigma_delta_storage_trigger,
    output logic [3:0] sigma_delta_storage_adr,
    output logic [3:0] log_address,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

    localparam logic [3:0] GAP_LAST = 4'(ISSUE_GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] stage_q, stage_d;
    logic [3:0] last_q, last_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] log_q, log_d;
    logic [4:0] bank_q, bank_d;
    logic       enable_q, enable_d;
    logic       done_q, done_d;

    logic       wb_valid_q [WB_LATENCY];
    logic [3:0] wb_stage_q [WB_LATENCY];
    logic       wb_fire;
    logic       last_wb;

    assign wb_fire = wb_valid_q[WB_LATENCY-1];
    assign last_wb = wb_fire && (wb_stage_q[WB_LATENCY-1] == last_q);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        log_d     = log_q;
        bank_d    = bank_q;
        enable_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_strobe && run) begin
                    state_d  = ISSUE;
                    stage_d  = 4'd0;
                    last_d   = num_stages_m1;
                    bank_d   = coef_bank;
                    log_d    = log_sel;
                    enable_d = 1'b1;
                end
            end
            ISSUE: begin
                gap_cnt_d = 4'd1;
                state_d   = (stage_q == last_q) ? DRAIN : GAP;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d  = ISSUE;
                    stage_d  = stage_q + 4'd1;
                    enable_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                // Only the final stage can write back here because WB_LATENCY <= ISSUE_GAP.
                if (last_wb) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_200) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            stage_q   <= 4'd0;
            last_q    <= 4'd0;
            gap_cnt_q <= 4'd0;
            log_q     <= 4'd0;
            bank_q    <= 5'd0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
            log_q     <= log_d;
            bank_q    <= bank_d;
            enable_q  <= enable_d;
            done_q    <= done_d;
        end
    end

    // Write-back pipeline: {valid, stage} delayed WB_LATENCY cycles behind the issue.
    for (genvar gi = 0; gi < WB_LATENCY; gi++) begin : g_wb
        if (gi == 0) begin : g_head
            always_ff @(posedge clock_200) begin
                if (!reset_n) begin
                    wb_valid_q[0] <= 1'b0;
                    wb_stage_q[0] <= 4'd0;
                end else begin
                    wb_valid_q[0] <= enable_q;
                    wb_stage_q[0] <= stage_q;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clock_200) begin
                if (!reset_n) begin
                    wb_valid_q[gi] <= 1'b0;
                    wb_stage_q[gi] <= 4'd0;
                end else begin
                    wb_valid_q[gi] <= wb_valid_q[gi-1];
                    wb_stage_q[gi] <= wb_stage_q[gi-1];
                end
            end
        end
    end

`ifdef SLICE_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (sample_strobe && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock_200) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clear;
    assign unused_overrun_clear = overrun_clear;
    assign overrun              = 1'b0;
`endif

    assign slice_enable                = enable_q;
    assign coefficient_read_adr        = {bank_q, stage_q};
    assign state_read_adr              = stage_q;
    assign sigma_delta_storage_trigger = wb_fire;
    assign state_write_adr             = wb_stage_q[WB_LATENCY-1];
    assign sigma_delta_storage_adr     = wb_stage_q[WB_LATENCY-1];
    assign log_address                 = log_q;
    assign busy                        = (state_q != IDLE);
    assign frame_done                  = done_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Testbench for slice_sequencer: directed frame scenarios plus randomized traffic against a schedule-based model.
module tb_slice_sequencer;

    localparam int G = 4;
    localparam int L = 4;
`ifdef SLICE_SEQ_OVERRUN_EN
    localparam logic OVR_ON = 1'b1;
`else
    localparam logic OVR_ON = 1'b0;
`endif

    logic       clock_200 = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_strobe = 1'b0;
    logic       run = 1'b0;
    logic [3:0] num_stages_m1 = 4'd0;
    logic [4:0] coef_bank = 5'd0;
    logic [3:0] log_sel = 4'd0;
    logic       overrun_clear = 1'b0;
    logic       slice_enable;
    logic [8:0] coefficient_read_adr;
    logic [3:0] state_read_adr;
    logic [3:0] state_write_adr;
    logic       sigma_delta_storage_trigger;
    logic [3:0] sigma_delta_storage_adr;
    logic [3:0] log_address;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    always #5 clock_200 = ~clock_200;

    slice_sequencer #(.ISSUE_GAP(G), .WB_LATENCY(L)) dut (
        .clock_200(clock_200),
        .reset_n(reset_n),
        .sample_strobe(sample_strobe),
        .run(run),
        .num_stages_m1(num_stages_m1),
        .coef_bank(coef_bank),
        .log_sel(log_sel),
        .overrun_clear(overrun_clear),
        .slice_enable(slice_enable),
        .coefficient_read_adr(coefficient_read_adr),
        .state_read_adr(state_read_adr),
        .state_write_adr(state_write_adr),
        .sigma_delta_storage_trigger(sigma_delta_storage_trigger),
        .sigma_delta_storage_adr(sigma_delta_storage_adr),
        .log_address(log_address),
        .busy(busy),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    int tests = 0;
    int fails = 0;
    int t = 0;

    // Model: the most recently accepted frame (start cycle, size, latched fields) and the overrun flag.
    bit         m_has = 1'b0;
    int         m_s = 0;
    int         m_n = 1;
    logic [4:0] m_bank = 5'd0;
    logic [3:0] m_log = 4'd0;
    logic       m_ovr = 1'b0;

    logic [29:0] obs_v, exp_v, msk_v;
    assign obs_v = {slice_enable, coefficient_read_adr, state_read_adr, sigma_delta_storage_trigger,
                    state_write_adr, sigma_delta_storage_adr, log_address, busy, frame_done, overrun};

    function automatic int done_cycle();
        return m_s + 1 + (m_n - 1) * G + L + 1;
    endfunction

    task automatic model_edge();
        bit idle;
        if (!reset_n) begin
            m_has = 1'b0;
            m_ovr = 1'b0;
        end else begin
            idle = !m_has || (t >= done_cycle());
            if (OVR_ON && sample_strobe && !idle) m_ovr = 1'b1;
            else if (OVR_ON && overrun_clear) m_ovr = 1'b0;
            if (sample_strobe && run && idle) begin
                m_has  = 1'b1;
                m_s    = t;
                m_n    = int'(num_stages_m1) + 1;
                m_bank = coef_bank;
                m_log  = log_sel;
            end
        end
    endtask

    task automatic build_expect();
        int r, k, rw;
        logic en, trig, bz, dn;
        logic [3:0] sk, wk;
        exp_v = '0;
        msk_v = '1;
        if (m_has) begin
            r    = t - m_s - 1;
            en   = (r % G == 0) && (r / G < m_n);
            k    = r / G;
            if (k > m_n - 1) k = m_n - 1;
            rw   = r - L;
            trig = (rw >= 0) && (rw % G == 0) && (rw / G < m_n);
            bz   = (t > m_s) && (t < done_cycle());
            dn   = (t == done_cycle());
            sk   = 4'(k);
            wk   = trig ? 4'(rw / G) : 4'd0;
            exp_v = {en, m_bank, sk, sk, trig, wk, wk, m_log, bz, dn, m_ovr};
            if (!trig) msk_v[14:7] = '0;
        end else begin
            exp_v[0] = m_ovr;
        end
    endtask

    task automatic step();
        @(posedge clock_200);
        model_edge();
        t++;
        #1;
        build_expect();
    endtask

    task automatic frame_inputs(input logic [3:0] n, input logic [4:0] b, input logic [3:0] lg);
        num_stages_m1 = n;
        coef_bank     = b;
        log_sel       = lg;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_strobe = 1'b1; run = 1'b1; overrun_clear = 1'b0;
        frame_inputs(4'd3, 5'd5, 4'd9);
        for (int c = 0; c < 3; c++) begin
            step();
            if (obs_v !== 30'd0) begin
                fails++; $display("FAIL reset_hold c=%0d got=%h exp=0", c, obs_v);
            end
            tests++;
        end
        reset_n = 1'b1; sample_strobe = 1'b0;
        step();
        if (obs_v !== 30'd0) begin
            fails++; $display("FAIL reset_release got=%h exp=0", obs_v);
        end
        tests++;
    endtask

    task automatic test_basic();
        int t0, rel, en_cnt, done_at;
        logic [31:0] en_bits, trig_bits, busy_bits;
        t0 = t; en_cnt = 0; done_at = -1; en_bits = 0; trig_bits = 0; busy_bits = 0;
        run = 1'b1; frame_inputs(4'd3, 5'd5, 4'hA);
        for (int c = 0; c < 22; c++) begin
            sample_strobe = (c == 0);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL basic_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (slice_enable) begin
                en_bits[rel] = 1'b1;
                if (coefficient_read_adr !== 9'h050 + 9'(en_cnt)) begin
                    fails++; $display("FAIL basic_coef rel=%0d got=%h exp=%h", rel, coefficient_read_adr, 9'h050 + 9'(en_cnt));
                end
                tests++;
                en_cnt++;
            end
            if (sigma_delta_storage_trigger) trig_bits[rel] = 1'b1;
            if (busy) busy_bits[rel] = 1'b1;
            if (frame_done) done_at = rel;
        end
        if (en_bits !== 32'h0000_2222) begin
            fails++; $display("FAIL basic_enables got=%h exp=00002222", en_bits);
        end
        if (trig_bits !== 32'h0002_2220) begin
            fails++; $display("FAIL basic_triggers got=%h exp=00022220", trig_bits);
        end
        if (busy_bits !== 32'h0003_FFFE) begin
            fails++; $display("FAIL basic_busy got=%h exp=0003fffe", busy_bits);
        end
        if (done_at != 18) begin
            fails++; $display("FAIL basic_done got=%0d exp=18", done_at);
        end
        tests += 4;
    endtask

    task automatic test_overrun();
        int t0, rel, done_at;
        logic ovr8, ovr20, ovr21;
        t0 = t; done_at = -1; ovr8 = 1'bx; ovr20 = 1'bx; ovr21 = 1'bx;
        run = 1'b1; frame_inputs(4'd3, 5'd5, 4'h3);
        for (int c = 0; c < 23; c++) begin
            sample_strobe = (c == 0) || (c == 7);
            overrun_clear = (c == 20);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL overrun_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (frame_done) done_at = rel;
            if (rel == 8) ovr8 = overrun;
            if (rel == 20) ovr20 = overrun;
            if (rel == 21) ovr21 = overrun;
        end
        overrun_clear = 1'b0;
        if (ovr8 !== OVR_ON || ovr20 !== OVR_ON) begin
            fails++; $display("FAIL overrun_set got=%b/%b exp=%b", ovr8, ovr20, OVR_ON);
        end
        if (ovr21 !== 1'b0) begin
            fails++; $display("FAIL overrun_clear got=%b exp=0", ovr21);
        end
        if (done_at != 18) begin
            fails++; $display("FAIL overrun_done got=%0d exp=18", done_at);
        end
        tests += 3;
    endtask

    task automatic test_single();
        int t0, rel, done_at;
        logic [15:0] en_bits, trig_bits;
        t0 = t; done_at = -1; en_bits = 0; trig_bits = 0;
        run = 1'b1; frame_inputs(4'd0, 5'd7, 4'h1);
        for (int c = 0; c < 10; c++) begin
            sample_strobe = (c == 0);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL single_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (slice_enable) en_bits[rel] = 1'b1;
            if (sigma_delta_storage_trigger) begin
                trig_bits[rel] = 1'b1;
                if (sigma_delta_storage_adr !== 4'd0) begin
                    fails++; $display("FAIL single_adr got=%0d exp=0", sigma_delta_storage_adr);
                end
                tests++;
            end
            if (frame_done) done_at = rel;
        end
        if (en_bits !== 16'h0002 || trig_bits !== 16'h0020) begin
            fails++; $display("FAIL single_pulses got=%h/%h exp=0002/0020", en_bits, trig_bits);
        end
        if (done_at != 6) begin
            fails++; $display("FAIL single_done got=%0d exp=6", done_at);
        end
        tests += 2;
    endtask

    task automatic test_max();
        int t0, rel, done_at, last_trig, en_cnt;
        t0 = t; done_at = -1; last_trig = -1; en_cnt = 0;
        run = 1'b1; frame_inputs(4'd15, 5'd31, 4'h6);
        for (int c = 0; c < 70; c++) begin
            sample_strobe = (c == 0);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL max_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (slice_enable) begin
                if (coefficient_read_adr !== 9'h1F0 + 9'(en_cnt)) begin
                    fails++; $display("FAIL max_coef rel=%0d got=%h exp=%h", rel, coefficient_read_adr, 9'h1F0 + 9'(en_cnt));
                end
                tests++;
                en_cnt++;
            end
            if (sigma_delta_storage_trigger) last_trig = rel;
            if (frame_done) done_at = rel;
        end
        if (en_cnt != 16 || last_trig != 65 || done_at != 66) begin
            fails++; $display("FAIL max_frame got=%0d/%0d/%0d exp=16/65/66", en_cnt, last_trig, done_at);
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        int t0, rel, stray;
        logic [29:0] at7;
        logic en11;
        logic [3:0] stage11;
        t0 = t; stray = 0; at7 = 'x; en11 = 1'bx; stage11 = 'x;
        run = 1'b1; frame_inputs(4'd3, 5'd5, 4'h2);
        for (int c = 0; c < 30; c++) begin
            sample_strobe = (c == 0) || (c == 10);
            reset_n = (c != 6);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL rstmid_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (rel == 7) at7 = obs_v;
            if (rel >= 7 && rel <= 11 && sigma_delta_storage_trigger) stray++;
            if (rel == 11) begin en11 = slice_enable; stage11 = state_read_adr; end
        end
        reset_n = 1'b1;
        if (at7 !== 30'd0) begin
            fails++; $display("FAIL rstmid_clear got=%h exp=0", at7);
        end
        if (stray != 0) begin
            fails++; $display("FAIL rstmid_stray got=%0d exp=0", stray);
        end
        if (en11 !== 1'b1 || stage11 !== 4'd0) begin
            fails++; $display("FAIL rstmid_restart got=%b/%0d exp=1/0", en11, stage11);
        end
        tests += 3;
    endtask

    task automatic test_run();
        int t0, rel, act, done_at, late;
        t0 = t; act = 0;
        run = 1'b0; frame_inputs(4'd3, 5'd5, 4'h4);
        for (int c = 0; c < 6; c++) begin
            sample_strobe = (c == 0);
            step();
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL runoff_cycle rel=%0d got=%h exp=%h", t - t0, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (busy || slice_enable) act++;
        end
        if (act != 0) begin
            fails++; $display("FAIL runoff_activity got=%0d exp=0", act);
        end
        tests++;
        t0 = t; done_at = -1; late = 0;
        for (int c = 0; c < 30; c++) begin
            sample_strobe = (c == 0) || (c == 20);
            run = (c < 3);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL rundrop_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (frame_done) done_at = rel;
            if (rel > 18 && (slice_enable || busy)) late++;
        end
        if (done_at != 18 || late != 0) begin
            fails++; $display("FAIL rundrop_frame got=%0d/%0d exp=18/0", done_at, late);
        end
        tests++;
    endtask

    task automatic test_back_to_back();
        int t0, rel;
        logic [15:0] en_bits;
        logic ovr7;
        t0 = t; en_bits = 0; ovr7 = 1'bx;
        run = 1'b1; frame_inputs(4'd0, 5'd9, 4'h8);
        for (int c = 0; c < 15; c++) begin
            sample_strobe = (c == 0) || (c == 6);
            overrun_clear = (c == 0);
            step();
            rel = t - t0;
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL b2b_cycle rel=%0d got=%h exp=%h", rel, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
            if (slice_enable) en_bits[rel] = 1'b1;
            if (rel == 7) ovr7 = overrun;
        end
        overrun_clear = 1'b0;
        if (en_bits !== 16'h0082 || ovr7 !== 1'b0) begin
            fails++; $display("FAIL b2b_accept got=%h/%b exp=0082/0", en_bits, ovr7);
        end
        tests++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            sample_strobe = ($urandom_range(0, 5) == 0);
            run           = ($urandom_range(0, 7) != 0);
            overrun_clear = ($urandom_range(0, 9) == 0);
            reset_n       = ($urandom_range(0, 149) != 0);
            frame_inputs(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            step();
            if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
                fails++; $display("FAIL random_cycle t=%0d got=%h exp=%h", t, obs_v & msk_v, exp_v & msk_v);
            end
            tests++;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_single();
        test_max();
        test_reset_mid();
        test_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
